// File: rtl/cache_mem_arbiter.sv
// Shared memory-port arbiter for the I-cache and D-cache fill engines: issues the
// eight word reads of each line fill, forwards write-through stores, and routes returning words.
module cache_mem_arbiter #(
    parameter int MEM_LATENCY    = 4,
    parameter int WORDS_PER_LINE = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        icache_miss,
    input  logic [15:0] icache_addr,
    input  logic        dcache_miss,
    input  logic [15:0] dcache_addr,
    input  logic        dcache_wr_req,
    input  logic [15:0] dcache_wr_addr,
    input  logic [15:0] dcache_wr_data,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_data,
    input  logic        mem_data_valid,
    output logic        icache_busy,
    output logic        dcache_busy,
    output logic        icache_fill_valid,
    output logic        dcache_fill_valid,
    output logic [2:0]  icache_fill_word,
    output logic [2:0]  dcache_fill_word,
    output logic [15:0] fill_data,
    output logic        icache_fill_done,
    output logic        dcache_fill_done,
    output logic        wr_ack
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    localparam logic [2:0] LAST_IDX = 3'(WORDS_PER_LINE - 1);

    state_t           state;
    owner_t           owner;
    owner_t           last_owner;
    owner_t           grant;
    logic [11:0]      line;
    logic [2:0]       ic;
    logic [MEM_LATENCY-1:0] dl_valid;
    logic [2:0]       dl_idx [MEM_LATENCY];
    logic             tail_valid;
    logic [2:0]       tail_idx;
    logic             store_go;
    logic             ret_valid;
    logic             unused_addr_bits;

    assign tail_valid       = dl_valid[MEM_LATENCY-1];
    assign tail_idx         = dl_idx[MEM_LATENCY-1];
    assign store_go         = ~rst & (state == IDLE) & dcache_wr_req;
    assign ret_valid        = ~rst & mem_data_valid & tail_valid;
    assign unused_addr_bits = ^{icache_addr[3:0], dcache_addr[3:0]};

    // On a miss tie the side that was not served last wins.
    always_comb begin
        grant = OWN_I;
        if (icache_miss && dcache_miss)
            grant = (last_owner == OWN_I) ? OWN_D : OWN_I;
        else if (dcache_miss)
            grant = OWN_D;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_I;
            last_owner <= OWN_I;
            line       <= '0;
            ic         <= '0;
            dl_valid   <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage shift from its pre-edge value.
            dl_valid[0] <= (state == ISSUE);
            for (int s = 1; s < MEM_LATENCY; s++)
                dl_valid[s] <= dl_valid[s-1];

            case (state)
                IDLE: begin
                    if (!dcache_wr_req && (icache_miss || dcache_miss)) begin
                        owner <= grant;
                        line  <= (grant == OWN_D) ? dcache_addr[15:4] : icache_addr[15:4];
                        ic    <= '0;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    ic <= ic + 3'd1;
                    if (ic == LAST_IDX) begin
                        state      <= DRAIN;
                        last_owner <= owner;
                    end
                end
                DRAIN: begin
                    if (tail_valid && tail_idx == LAST_IDX)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: index stages carry no reset; they are only observed when the matching valid bit is set.
    always_ff @(posedge clk) begin
        dl_idx[0] <= ic;
        for (int s = 1; s < MEM_LATENCY; s++)
            dl_idx[s] <= dl_idx[s-1];
    end

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        wr_ack    = 1'b0;
        if (store_go) begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = dcache_wr_addr;
            mem_wdata = dcache_wr_data;
            wr_ack    = 1'b1;
        end else if (!rst && state == ISSUE) begin
            mem_en   = 1'b1;
            mem_addr = {line, ic, 1'b0};
        end
    end

    assign icache_fill_valid = ret_valid & (owner == OWN_I);
    assign dcache_fill_valid = ret_valid & (owner == OWN_D);
    assign icache_fill_word  = icache_fill_valid ? tail_idx : 3'd0;
    assign dcache_fill_word  = dcache_fill_valid ? tail_idx : 3'd0;
    assign icache_fill_done  = icache_fill_valid & (tail_idx == LAST_IDX);
    assign dcache_fill_done  = dcache_fill_valid & (tail_idx == LAST_IDX);
    assign fill_data         = mem_data;

    assign icache_busy = ~rst & (icache_miss | ((state != IDLE) & (owner == OWN_I)));
    assign dcache_busy = ~rst & (dcache_miss | ((state != IDLE) & (owner == OWN_D))
                                 | (dcache_wr_req & ~wr_ack));

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: pipelined memory model, fill-return scoreboard,
// a per-cycle vector table for a D fill, and directed multi-cycle corner sequences.
module tb_cache_mem_arbiter;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        icache_miss, dcache_miss, dcache_wr_req;
    logic [15:0] icache_addr, dcache_addr, dcache_wr_addr, dcache_wr_data;
    logic        mem_en, mem_wr, mem_data_valid;
    logic [15:0] mem_addr, mem_wdata, mem_data, fill_data;
    logic        icache_busy, dcache_busy, icache_fill_valid, dcache_fill_valid;
    logic [2:0]  icache_fill_word, dcache_fill_word;
    logic        icache_fill_done, dcache_fill_done, wr_ack;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    cache_mem_arbiter #(.MEM_LATENCY(L), .WORDS_PER_LINE(8)) dut (
        .clk(clk), .rst(rst),
        .icache_miss(icache_miss), .icache_addr(icache_addr),
        .dcache_miss(dcache_miss), .dcache_addr(dcache_addr),
        .dcache_wr_req(dcache_wr_req), .dcache_wr_addr(dcache_wr_addr),
        .dcache_wr_data(dcache_wr_data),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_data(mem_data), .mem_data_valid(mem_data_valid),
        .icache_busy(icache_busy), .dcache_busy(dcache_busy),
        .icache_fill_valid(icache_fill_valid), .dcache_fill_valid(dcache_fill_valid),
        .icache_fill_word(icache_fill_word), .dcache_fill_word(dcache_fill_word),
        .fill_data(fill_data),
        .icache_fill_done(icache_fill_done), .dcache_fill_done(dcache_fill_done),
        .wr_ack(wr_ack)
    );

    // Memory model: a read issued in cycle c returns 0x1000 + word index in cycle c+L.
    logic [L-1:0] pv = '0;
    logic [15:0]  pd [L];
    logic         spur = 1'b0;
    always @(posedge clk) begin
        pv    <= {pv[L-2:0], mem_en & ~mem_wr};
        pd[0] <= 16'h1000 + {13'd0, mem_addr[3:1]};
        for (int s = 1; s < L; s++) pd[s] <= pd[s-1];
    end
    assign mem_data_valid = pv[L-1] | spur;
    assign mem_data       = spur ? 16'hDEAD : pd[L-1];

    typedef struct {
        bit          side;   // 1 = D, 0 = I
        logic [2:0]  idx;
        logic [15:0] data;
    } sb_t;
    sb_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_fill(input bit side, input int count);
        for (int i = 0; i < count; i++) begin
            sb_t e;
            e.side = side;
            e.idx  = 3'(i);
            e.data = 16'h1000 + 16'(i);
            sb.push_back(e);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Return monitor: every delivered fill word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && (icache_fill_valid || dcache_fill_valid)) begin
            if (sb.size() == 0) begin
                check("sb_unexpected", {30'd0, dcache_fill_valid, icache_fill_valid}, 32'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                check("sb_side", {30'd0, dcache_fill_valid, icache_fill_valid},
                      e.side ? 32'd2 : 32'd1);
                check("sb_word", {29'd0, e.side ? dcache_fill_word : icache_fill_word},
                      {29'd0, e.idx});
                check("sb_data", {16'd0, fill_data}, {16'd0, e.data});
                check("sb_done", {31'd0, e.side ? dcache_fill_done : icache_fill_done},
                      {31'd0, e.idx == 3'd7});
            end
        end
    end

    typedef struct {
        logic        dmiss;
        logic        en;
        logic [15:0] addr;
        logic        dbusy;
        logic        dfv;
        logic [2:0]  word;
        logic        ddone;
    } vec_t;
    vec_t tbl[14];

    initial begin
        for (int k = 0; k < 14; k++) begin
            tbl[k].dmiss = (k <= 12);
            tbl[k].en    = (k >= 1 && k <= 8);
            tbl[k].addr  = tbl[k].en ? 16'h3A50 + 16'(2 * (k - 1)) : 16'h0000;
            tbl[k].dbusy = (k <= 12);
            tbl[k].dfv   = (k >= 5 && k <= 12);
            tbl[k].word  = tbl[k].dfv ? 3'(k - 5) : 3'd0;
            tbl[k].ddone = (k == 12);
        end

        rst = 1'b1; spur = 1'b1;
        icache_miss = 0; dcache_miss = 0; dcache_wr_req = 0;
        icache_addr = 0; dcache_addr = 0; dcache_wr_addr = 0; dcache_wr_data = 0;

        // Reset values, with a stray valid pulse present.
        @(negedge clk);
        check("rst mem_en", {31'd0, mem_en}, 0);
        check("rst mem_addr", {16'd0, mem_addr}, 0);
        check("rst wr_ack", {31'd0, wr_ack}, 0);
        check("rst busy", {30'd0, icache_busy, dcache_busy}, 0);
        check("rst fill_valid", {30'd0, icache_fill_valid, dcache_fill_valid}, 0);
        check("rst fill_done", {30'd0, icache_fill_done, dcache_fill_done}, 0);
        check("rst fill_data", {16'd0, fill_data}, 32'hDEAD);
        next_cycle();
        rst = 1'b0; spur = 1'b0;

        // Single D fill, per-cycle vector table.
        push_fill(1'b1, 8);
        for (int k = 0; k < 14; k++) begin
            dcache_miss = tbl[k].dmiss;
            dcache_addr = 16'h3A56;
            @(negedge clk);
            check($sformatf("dfill c%0d en", k), {31'd0, mem_en}, {31'd0, tbl[k].en});
            check($sformatf("dfill c%0d addr", k), {16'd0, mem_addr}, {16'd0, tbl[k].addr});
            check($sformatf("dfill c%0d wr", k), {31'd0, mem_wr}, 0);
            check($sformatf("dfill c%0d dbusy", k), {31'd0, dcache_busy}, {31'd0, tbl[k].dbusy});
            check($sformatf("dfill c%0d dfv", k), {31'd0, dcache_fill_valid}, {31'd0, tbl[k].dfv});
            check($sformatf("dfill c%0d dword", k), {29'd0, dcache_fill_word}, {29'd0, tbl[k].word});
            check($sformatf("dfill c%0d ddone", k), {31'd0, dcache_fill_done}, {31'd0, tbl[k].ddone});
            check($sformatf("dfill c%0d ifv", k), {31'd0, icache_fill_valid}, 0);
            next_cycle();
        end

        // Tie at reset release: D first, then I from the first IDLE cycle.
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        icache_addr = 16'hC0DE;
        dcache_addr = 16'h4321;
        push_fill(1'b1, 8);
        push_fill(1'b0, 8);
        for (int k = 0; k <= 25; k++) begin
            icache_miss = 1'b1;
            dcache_miss = (k <= 12);
            @(negedge clk);
            check($sformatf("tie c%0d ibusy", k), {31'd0, icache_busy}, 1);
            if (k == 1) check("tie d addr", {16'd0, mem_addr}, 32'h4320);
            if (k == 13) check("tie gap en", {31'd0, mem_en}, 0);
            if (k == 14) check("tie i en", {31'd0, mem_en}, 1);
            if (k == 14) check("tie i addr", {16'd0, mem_addr}, 32'hC0D0);
            if (k == 25) check("tie i done", {31'd0, icache_fill_done}, 1);
            next_cycle();
        end
        icache_miss = 1'b0;

        // Store priority over a pending I miss.
        push_fill(1'b0, 8);
        for (int k = 0; k <= 13; k++) begin
            icache_miss    = 1'b1;
            icache_addr    = 16'h5550;
            dcache_wr_req  = (k == 0);
            dcache_wr_addr = 16'h0100;
            dcache_wr_data = 16'hBEEF;
            @(negedge clk);
            if (k == 0) begin
                check("st mem_wr", {31'd0, mem_wr}, 1);
                check("st mem_addr", {16'd0, mem_addr}, 32'h0100);
                check("st mem_wdata", {16'd0, mem_wdata}, 32'hBEEF);
                check("st wr_ack", {31'd0, wr_ack}, 1);
            end
            if (k == 1) check("st grant wait en", {31'd0, mem_en}, 0);
            if (k == 2) check("st i issue", {14'd0, mem_en, mem_wr, mem_addr}, 32'h2_5550);
            if (k == 13) check("st i done", {31'd0, icache_fill_done}, 1);
            next_cycle();
        end
        icache_miss = 1'b0;

        // Store raised during a D fill waits for the first IDLE cycle.
        push_fill(1'b1, 8);
        for (int k = 0; k <= 14; k++) begin
            dcache_miss    = (k <= 12);
            dcache_addr    = 16'h0AB0;
            dcache_wr_req  = (k >= 3 && k <= 13);
            dcache_wr_addr = 16'h0200;
            dcache_wr_data = 16'h1234;
            @(negedge clk);
            if (k >= 3 && k <= 12) begin
                check($sformatf("swf c%0d wr_ack", k), {31'd0, wr_ack}, 0);
                check($sformatf("swf c%0d dbusy", k), {31'd0, dcache_busy}, 1);
            end
            if (k == 12) check("swf done", {31'd0, dcache_fill_done}, 1);
            if (k == 13) begin
                check("swf ack", {30'd0, wr_ack, mem_wr}, 3);
                check("swf addr", {mem_addr, mem_wdata}, 32'h0200_1234);
            end
            if (k == 14) check("swf after", {30'd0, mem_en, dcache_busy}, 0);
            next_cycle();
        end
        dcache_wr_req = 1'b0;

        // Reset in cycle 6 of an I fill; valid keeps pulsing afterwards.
        push_fill(1'b0, 1);
        for (int k = 0; k <= 13; k++) begin
            icache_miss = (k <= 5);
            icache_addr = 16'h7770;
            rst         = (k == 6);
            spur        = (k >= 6 && k <= 12);
            @(negedge clk);
            if (k == 5) check("rmf word0 valid", {31'd0, icache_fill_valid}, 1);
            if (k >= 6) begin
                check($sformatf("rmf c%0d fv", k), {30'd0, icache_fill_valid, dcache_fill_valid}, 0);
                check($sformatf("rmf c%0d done", k), {30'd0, icache_fill_done, dcache_fill_done}, 0);
                check($sformatf("rmf c%0d en", k), {31'd0, mem_en}, 0);
                check($sformatf("rmf c%0d ibusy", k), {31'd0, icache_busy}, 0);
            end
            next_cycle();
        end
        rst = 1'b0; spur = 1'b0;

        // Spurious valid while IDLE.
        for (int k = 0; k < 3; k++) begin
            spur = 1'b1;
            @(negedge clk);
            check($sformatf("spur c%0d fv", k), {30'd0, icache_fill_valid, dcache_fill_valid}, 0);
            check($sformatf("spur c%0d done", k), {30'd0, icache_fill_done, dcache_fill_done}, 0);
            next_cycle();
        end
        spur = 1'b0;

        check("sb drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shared main-memory port arbiter that sits directly downstream of the I-cache and D-cache fill state machines. It accepts line-fill misses from both caches and single-word write-through stores from the D-side, and sequences them onto the one pipelined memory port. For each fill it issues the eight word reads of a 16-byte line. It then routes the returning data, tagged with its word index, back to the cache that owns the fill.

## Interface
Parameters:
- MEM_LATENCY, 4: cycles from a read issue (mem_en=1, mem_wr=0) to the matching mem_data_valid.
- WORDS_PER_LINE, 8: 16-bit words per cache line. Fixed; the line offset is address bits [3:1].

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- icache_miss  in  1  I-side fill request, level; held until icache_fill_done
- icache_addr  in  16  I-side miss address; only [15:4] used
- dcache_miss  in  1  D-side fill request, level
- dcache_addr  in  16  D-side miss address; only [15:4] used
- dcache_wr_req  in  1  D-side write-through store request, level
- dcache_wr_addr  in  16  store address
- dcache_wr_data  in  16  store data
- mem_en  out  1  memory access enable
- mem_wr  out  1  1 = write, 0 = read
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_data  in  16  memory read data
- mem_data_valid  in  1  mem_data valid this cycle
- icache_busy, dcache_busy  out  1  stall signal to each cache
- icache_fill_valid, dcache_fill_valid  out  1  fill word present this cycle
- icache_fill_word, dcache_fill_word  out  3  word index of the fill data
- fill_data  out  16  mem_data forwarded unregistered, shared by both sides
- icache_fill_done, dcache_fill_done  out  1  one-cycle pulse with the last word of a fill
- wr_ack  out  1  store accepted this cycle

## Operation
- States: IDLE, ISSUE, DRAIN. Registers: state, owner (I/D), last_owner, line[15:4], issue count ic[2:0], return-index delay line (MEM_LATENCY stages of {valid, idx[2:0]}).
- **IDLE, priority rules:**
  - dcache_wr_req has top priority. mem_en=1, mem_wr=1, mem_addr=dcache_wr_addr, mem_wdata=dcache_wr_data, and wr_ack=1 combinationally in the same cycle. State stays IDLE. No miss is accepted that cycle.
  - Otherwise, if exactly one miss is asserted, latch that side's addr[15:4] into line, set owner to that side, set ic=0, and go to ISSUE.
  - If both misses are asserted, grant the side != last_owner. last_owner resets to I, so D wins the first tie.
- **ISSUE:** mem_en=1, mem_wr=0, mem_addr={line, ic, 1'b0}, mem_wdata=0.
  - Push {1, ic} into the delay line; ic increments each cycle.
  - After issuing ic=7, go to DRAIN and set last_owner=owner.
- **DRAIN:** mem_en=0. Go to IDLE the cycle after the delay-line tail with idx=7 returns.
- **Return path:**
  - fill_valid for owner = mem_data_valid & tail.valid; fill_word = tail.idx.
  - The non-owner's fill_valid = 0.
  - fill_done for owner = fill_valid & (tail.idx==7).
  - mem_data_valid with an invalid tail is ignored.
- **Busy:** x_busy = x_miss | (state!=IDLE & owner==x) | (x==D & dcache_wr_req & ~wr_ack).
- **Stores during a fill:** a store arriving while state!=IDLE waits; wr_ack=0 and dcache_busy=1.
- **Idle outputs:** when not issuing or writing, mem_en=0, mem_wr=0, mem_addr=0, mem_wdata=0.
- **Reset mid-fill:** state→IDLE and delay line cleared. Late mem_data_valid pulses are dropped, with no fill_valid and no fill_done. owner→I and last_owner→I.

## Timing
- **Reset values:** all outputs 0 except fill_data, which follows mem_data.
- **Fill latency** (miss seen in IDLE at edge 0):
  - ISSUE in cycles 1–8.
  - Returns in cycles 1+L … 8+L, with L=MEM_LATENCY (cycles 5–12 for L=4).
  - fill_done in cycle 8+L.
  - IDLE in cycle 9+L.
- **Back-to-back:** a new miss can be accepted in the first IDLE cycle, so the minimum gap between fills is 1 idle cycle.
- **Store:** zero-latency ack in IDLE. A store present together with a miss delays the miss grant by one cycle.
- **Simultaneous events:**
  - A miss deasserting mid-fill has no effect; the fill completes.
  - A miss for the other side waits in busy.

## Test plan
- **Single D fill:** rst low, dcache_addr=0x3A56, dcache_miss=1; memory model returns 0x1000+idx at L=4.
  - mem_addr must be 0x3A50, 0x3A52 … 0x3A5E on cycles 1–8.
  - dcache_fill_valid in cycles 5–12 with word 0–7 and data 0x1000–0x1007.
  - dcache_fill_done in cycle 12 only; icache_fill_valid always 0.
- **Tie then alternate:** both misses asserted at reset release.
  - D is served first (addr from dcache_addr).
  - I starts ISSUE in cycle 14 (first IDLE at 13, grant at edge 13).
  - icache_busy=1 throughout.
- **Store priority:** dcache_wr_req=1, addr 0x0100, data 0xBEEF, together with icache_miss.
  - Cycle 0: mem_wr=1, mem_addr=0x0100, mem_wdata=0xBEEF, wr_ack=1.
  - The I fill issues starting cycle 2.
- **Store during fill:** wr_req raised in cycle 3 of a D fill.
  - wr_ack stays 0 and dcache_busy=1 until the first IDLE cycle (13), where wr_ack=1 and mem_wr=1.
- **Reset mid-fill:** rst=1 in cycle 6 of a fill while the model keeps pulsing valid through cycle 12.
  - After reset: no fill_valid and no fill_done; state IDLE; mem_en=0.
- **Spurious valid:** mem_data_valid=1 while IDLE → both fill_valid=0 and both fill_done=0.
